// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (3 read, 2 write) with a per-register load scoreboard.
// The top index reads PC_in. Define REGFILE_BYPASS_EN to add same-cycle write-through forwarding.
module regfile_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned PC_IDX = 2**ADDR_W - 1
) (
   input  logic              CLK_n,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   input  logic [ADDR_W-1:0] RA3,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] RD3,
   output logic              Busy1,
   output logic              Busy2,
   output logic              Busy3,
   input  logic [DATA_W-1:0] PC_in,
   input  logic              WE_A,
   input  logic [ADDR_W-1:0] WA_A,
   input  logic [DATA_W-1:0] WD_A,
   input  logic              WE_B,
   input  logic [ADDR_W-1:0] WA_B,
   input  logic [DATA_W-1:0] WD_B,
   input  logic              Claim,
   input  logic [ADDR_W-1:0] ClaimAddr,
   output logic              AnyBusy
);

   localparam int unsigned       NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   // The PC slot entries are never written, so they stay at their reset value and prune away.
   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;

   // Storage and scoreboard update; port A wins data on a same-address collision.
   always_ff @(posedge CLK_n or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r[ADDR_W-1:0]] <= '0;
         end
         busy <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (r[ADDR_W-1:0] != PC_A) begin
               if (WE_A && (WA_A == r[ADDR_W-1:0])) begin
                  regs[r[ADDR_W-1:0]] <= WD_A;
               end else if (WE_B && (WA_B == r[ADDR_W-1:0])) begin
                  regs[r[ADDR_W-1:0]] <= WD_B;
               end
               // A new claim re-targets the register, so it beats a retiring load.
               if (Claim && (ClaimAddr == r[ADDR_W-1:0])) begin
                  busy[r[ADDR_W-1:0]] <= 1'b1;
               end else if (WE_B && (WA_B == r[ADDR_W-1:0])) begin
                  busy[r[ADDR_W-1:0]] <= 1'b0;
               end
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (WE_A && (WA_A == a)) begin
         v = WD_A;
      end else if (WE_B && (WA_B == a)) begin
         v = WD_B;
      end
`endif
      if (a == PC_A) begin
         v = PC_in;
      end
      return v;
   endfunction

   function automatic logic busy_port(input logic [ADDR_W-1:0] a);
      logic b;
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (WE_B && (WA_B == a) && !(Claim && (ClaimAddr == a))) begin
         b = 1'b0;
      end
`endif
      if (a == PC_A) begin
         b = 1'b0;
      end
      return b;
   endfunction

   assign RD1     = rd_port(RA1);
   assign RD2     = rd_port(RA2);
   assign RD3     = rd_port(RA3);
   assign Busy1   = busy_port(RA1);
   assign Busy2   = busy_port(RA2);
   assign Busy3   = busy_port(RA3);
   assign AnyBusy = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table, randomized run against a behavioural model, and
// hand sequences for same-cycle forwarding and asynchronous reset.
module tb_regfile_mp;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 4;
   localparam int unsigned NR  = 16;
   localparam logic [3:0]  PCI = 4'd15;

   logic          CLK_n, Reset_n;
   logic [AW-1:0] RA1, RA2, RA3;
   logic [DW-1:0] RD1, RD2, RD3;
   logic          Busy1, Busy2, Busy3;
   logic [DW-1:0] PC_in;
   logic          WE_A, WE_B, Claim;
   logic [AW-1:0] WA_A, WA_B, ClaimAddr;
   logic [DW-1:0] WD_A, WD_B;
   logic          AnyBusy;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK_n(CLK_n), .Reset_n(Reset_n),
      .RA1(RA1), .RA2(RA2), .RA3(RA3),
      .RD1(RD1), .RD2(RD2), .RD3(RD3),
      .Busy1(Busy1), .Busy2(Busy2), .Busy3(Busy3),
      .PC_in(PC_in),
      .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
      .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
      .Claim(Claim), .ClaimAddr(ClaimAddr),
      .AnyBusy(AnyBusy)
   );

   initial begin
      CLK_n = 1'b0;
      forever #5 CLK_n = ~CLK_n;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      WE_A = 1'b0; WA_A = '0; WD_A = '0;
      WE_B = 1'b0; WA_B = '0; WD_B = '0;
      Claim = 1'b0; ClaimAddr = '0;
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_reg  [NR];
   logic        m_busy [NR];

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      logic [31:0] v;
      if (a == PCI) return PC_in;
      v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
      if (WE_B && WA_B == a) v = WD_B;
      if (WE_A && WA_A == a) v = WD_A;
`endif
      return v;
   endfunction

   function automatic logic exp_busy(input logic [3:0] a);
      logic b;
      if (a == PCI) return 1'b0;
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (WE_B && WA_B == a && !(Claim && ClaimAddr == a)) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic logic exp_any();
      logic o;
      o = 1'b0;
      for (int i = 0; i < NR; i++) o |= m_busy[i];
      return o;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (WE_B && WA_B != PCI) begin
         m_reg[WA_B]  = WD_B;
         m_busy[WA_B] = 1'b0;
      end
      if (WE_A && WA_A != PCI) m_reg[WA_A] = WD_A;
      if (Claim && ClaimAddr != PCI) m_busy[ClaimAddr] = 1'b1;
   endtask

   function automatic logic [3:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 15));
      return 4'($urandom_range(12, 15));
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        we_a; logic [3:0] wa_a; logic [31:0] wd_a;
      logic        we_b; logic [3:0] wa_b; logic [31:0] wd_b;
      logic        cl;   logic [3:0] ca;
      logic [3:0]  r1, r2, r3;
      logic [31:0] pc;
      logic [31:0] e1, e2, e3;
      logic [2:0]  eb;
      logic        ea;
   } vec_t;

   function automatic vec_t mk(input logic we_a, input logic [3:0] wa_a, input logic [31:0] wd_a,
                               input logic we_b, input logic [3:0] wa_b, input logic [31:0] wd_b,
                               input logic cl, input logic [3:0] ca,
                               input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                               input logic [31:0] pc,
                               input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                               input logic [2:0] eb, input logic ea);
      vec_t v;
      v.we_a = we_a; v.wa_a = wa_a; v.wd_a = wd_a;
      v.we_b = we_b; v.wa_b = wa_b; v.wd_b = wd_b;
      v.cl = cl; v.ca = ca; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.pc = pc;
      v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eb = eb; v.ea = ea;
      return v;
   endfunction

   localparam int NV = 12;
   vec_t tv [NV];

   initial begin
      Reset_n = 1'b0;
      RA1 = '0; RA2 = '0; RA3 = '0; PC_in = '0;
      idle();

      // Row expectations reflect state committed by earlier rows; no row reads an address it writes.
      //         weA waA wdA     weB waB wdB   cl ca  r1 r2 r3 pc           e1       e2     e3     eb    ea
      tv[0]  = mk(1, 1, 32'hA,    1, 2, 32'hB,  0, 0, 15, 0, 3, 32'h108,    32'h108, 0,     0,     3'b000, 0);
      tv[1]  = mk(1, 5, 32'h11,   1, 5, 32'h22, 0, 0,  1, 2, 15, 32'h108,   32'hA,   32'hB, 32'h108, 3'b000, 0);
      tv[2]  = mk(1, 15, 32'hDEAD, 0, 0, 0,     1, 4,  5, 15, 0, 32'h200,   32'h11,  32'h200, 0,    3'b000, 0);
      tv[3]  = mk(0, 0, 0,        0, 0, 0,      0, 0,  4, 15, 5, 32'h300,   0,       32'h300, 32'h11, 3'b001, 1);
      tv[4]  = mk(0, 0, 0,        1, 4, 32'h77, 0, 0,  1, 2, 3, 0,          32'hA,   32'hB, 0,     3'b000, 1);
      tv[5]  = mk(0, 0, 0,        0, 0, 0,      0, 0,  4, 14, 15, 0,        32'h77,  0,     0,     3'b000, 0);
      tv[6]  = mk(0, 0, 0,        1, 4, 32'h55, 1, 4,  1, 5, 2, 0,          32'hA,   32'h11, 32'hB, 3'b000, 0);
      tv[7]  = mk(0, 0, 0,        0, 0, 0,      0, 0,  4, 4, 4, 0,          32'h55,  32'h55, 32'h55, 3'b111, 1);
      tv[8]  = mk(0, 0, 0,        1, 4, 32'h66, 0, 0,  0, 13, 15, 32'h1,    0,       0,     32'h1, 3'b000, 1);
      tv[9]  = mk(0, 0, 0,        0, 0, 0,      1, 15, 4, 5, 1, 0,          32'h66,  32'h11, 32'hA, 3'b000, 0);
      tv[10] = mk(0, 0, 0,        0, 0, 0,      0, 0, 15, 15, 15, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 0);
      tv[11] = mk(0, 0, 0,        0, 0, 0,      0, 0, 14, 13, 12, 0,        0,       0,     0,     3'b000, 0);

      // Reset state while Reset_n is held low
      repeat (2) @(negedge CLK_n);
      RA1 = 4'd0; RA2 = 4'd7; RA3 = PCI; PC_in = 32'h0000_0108;
      #1;
      chk("reset.rd1", RD1, 32'h0);
      chk("reset.rd2", RD2, 32'h0);
      chk("reset.rd3_pc", RD3, 32'h108);
      chk("reset.busy", 32'({Busy3, Busy2, Busy1}), 32'h0);
      chk("reset.anybusy", 32'(AnyBusy), 32'h0);
      @(negedge CLK_n);
      Reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge CLK_n);
         WE_A = tv[i].we_a; WA_A = tv[i].wa_a; WD_A = tv[i].wd_a;
         WE_B = tv[i].we_b; WA_B = tv[i].wa_b; WD_B = tv[i].wd_b;
         Claim = tv[i].cl; ClaimAddr = tv[i].ca;
         RA1 = tv[i].r1; RA2 = tv[i].r2; RA3 = tv[i].r3; PC_in = tv[i].pc;
         #1;
         chk($sformatf("vec%0d.rd1", i), RD1, tv[i].e1);
         chk($sformatf("vec%0d.rd2", i), RD2, tv[i].e2);
         chk($sformatf("vec%0d.rd3", i), RD3, tv[i].e3);
         chk($sformatf("vec%0d.busy", i), 32'({Busy3, Busy2, Busy1}), 32'(tv[i].eb));
         chk($sformatf("vec%0d.anybusy", i), 32'(AnyBusy), 32'(tv[i].ea));
      end

      // Randomized run against the model, starting from a fresh reset
      @(negedge CLK_n);
      idle();
      Reset_n = 1'b0;
      model_clear();
      @(negedge CLK_n);
      Reset_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK_n);
         WE_A = 1'($urandom_range(0, 1)); WA_A = rnd_addr(); WD_A = $urandom;
         WE_B = 1'($urandom_range(0, 1)); WA_B = rnd_addr(); WD_B = $urandom;
         Claim = ($urandom_range(0, 2) == 0); ClaimAddr = rnd_addr();
         RA1 = rnd_addr(); RA2 = rnd_addr(); RA3 = rnd_addr(); PC_in = $urandom;
         #1;
         chk($sformatf("rnd%0d.rd1", c), RD1, exp_rd(RA1));
         chk($sformatf("rnd%0d.rd2", c), RD2, exp_rd(RA2));
         chk($sformatf("rnd%0d.rd3", c), RD3, exp_rd(RA3));
         chk($sformatf("rnd%0d.busy", c), 32'({Busy3, Busy2, Busy1}),
             32'({exp_busy(RA3), exp_busy(RA2), exp_busy(RA1)}));
         chk($sformatf("rnd%0d.anybusy", c), 32'(AnyBusy), 32'(exp_any()));
         model_edge();
      end

      // Same-cycle read of a register being written through port A
      @(negedge CLK_n);
      idle();
      WE_A = 1'b1; WA_A = 4'd6; WD_A = 32'h10;
      @(negedge CLK_n);
      WE_A = 1'b1; WA_A = 4'd6; WD_A = 32'h99; RA3 = 4'd6;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass.same_cycle", RD3, 32'h99);
`else
      chk("bypass.same_cycle", RD3, 32'h10);
`endif
      @(negedge CLK_n);
      idle();
      #1;
      chk("bypass.next_cycle", RD3, 32'h99);

      // Asynchronous reset mid-cycle with an outstanding claim
      @(negedge CLK_n);
      WE_A = 1'b1; WA_A = 4'd3; WD_A = 32'h1234; Claim = 1'b1; ClaimAddr = 4'd7;
      @(negedge CLK_n);
      idle();
      RA1 = 4'd3; RA2 = 4'd7; RA3 = 4'd3;
      #1;
      chk("arst.pre_rd1", RD1, 32'h1234);
      chk("arst.pre_busy2", 32'(Busy2), 32'h1);
      chk("arst.pre_anybusy", 32'(AnyBusy), 32'h1);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("arst.rd1", RD1, 32'h0);
      chk("arst.busy", 32'({Busy3, Busy2, Busy1}), 32'h0);
      chk("arst.anybusy", 32'(AnyBusy), 32'h0);
      @(negedge CLK_n);
      Reset_n = 1'b1;
      WE_B = 1'b1; WA_B = 4'd7; WD_B = 32'h42;
      #1;
      chk("arst.plainwr_busy2", 32'(Busy2), 32'h0);
      @(negedge CLK_n);
      idle();
      #1;
      chk("arst.plainwr_rd2", RD2, 32'h42);
      chk("arst.plainwr_busy2b", 32'(Busy2), 32'h0);
      chk("arst.plainwr_anybusy", 32'(AnyBusy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-write-port core register bank.
- Provides three combinational read ports: Rn, Rm and Rs (for register-shifted operands).
- Provides two write ports: port A is ALU writeback, port B is memory/load writeback.
- Holds a per-register busy scoreboard so the hazard unit can stall on outstanding loads. The top register index reads from the PC input.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; register count is 2**ADDR_W including the PC slot
PC_IDX, 2**ADDR_W-1, index that maps to PC_in; it has no storage and no busy bit

Ports:
CLK_n  input  1  clock; all state updates on its rising edge
Reset_n  input  1  asynchronous active-low reset
RA1  input  ADDR_W  read address, port 1
RA2  input  ADDR_W  read address, port 2
RA3  input  ADDR_W  read address, port 3
RD1  output  DATA_W  read data, port 1
RD2  output  DATA_W  read data, port 2
RD3  output  DATA_W  read data, port 3
Busy1  output  1  busy flag of register RA1
Busy2  output  1  busy flag of register RA2
Busy3  output  1  busy flag of register RA3
PC_in  input  DATA_W  value returned for reads of PC_IDX
WE_A  input  1  write enable, port A
WA_A  input  ADDR_W  write address, port A
WD_A  input  DATA_W  write data, port A
WE_B  input  1  write enable, port B; a port-B write also clears the busy bit
WA_B  input  ADDR_W  write address, port B
WD_B  input  DATA_W  write data, port B
Claim  input  1  set the busy bit of ClaimAddr (load issued)
ClaimAddr  input  ADDR_W  register claimed by the outstanding load
AnyBusy  output  1  OR of all busy bits

Behaviour:
- Storage is 2**ADDR_W-1 registers of DATA_W bits, plus busy[2**ADDR_W-2:0].
- Reset_n low, asynchronous and independent of CLK_n:
  - all registers cleared to 0;
  - all busy bits cleared;
  - RD* return 0 for non-PC addresses; Busy* and AnyBusy are 0.
- Reset asserted mid-load clears the claim; a later port-B write is a plain write.
- Reads are combinational, zero latency:
  - RDn = PC_in when RAn == PC_IDX, else the stored value;
  - Busyn = 0 when RAn == PC_IDX, else busy[RAn].
- Writes happen at the CLK_n rising edge when WE_x = 1 and WA_x != PC_IDX.
- A write to PC_IDX is silently dropped: no storage change, no busy change. PC writes are handled by the fetch stage.
- If WE_A and WE_B both target the same address in one cycle, port A data wins (younger instruction). The busy bit is still cleared by port B.
- Writes to different addresses in the same cycle both complete.
- Scoreboard update at the rising edge for register r:
  - Claim && ClaimAddr == r sets busy[r];
  - else WE_B && WA_B == r clears busy[r];
  - else busy[r] holds.
- Claim and a port-B clear on the same register in the same cycle: Claim wins and busy stays 1, because a new load is re-targeting the register.
- Claim on PC_IDX is ignored.
- A port-A write does not affect busy bits.
- AnyBusy is combinational from the busy vector (for pipeline drain / interrupt entry).
- Without the optional feature, a read of a register written in the same cycle returns the old value; the new value is visible from the next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined, write-through forwarding is added to every read port:
  - if RAn != PC_IDX and it matches an enabled write this cycle, RDn returns the write data, with port A taking priority over port B;
  - Busyn reads 0 when the same cycle has a port-B write to RAn and no Claim on RAn.
- When undefined: no forwarding paths. Reads see only stored state, and Busyn shows the registered busy bit.

Test Plan:
- Reset check: assert Reset_n=0 mid-cycle after writing R3=0x1234 -> RD1 (RA1=3) reads 0 immediately, before any CLK_n edge; Busy*=0; AnyBusy=0.
- PC slot: RA2=15, PC_in=0x0000_0108 -> RD2=0x108 and Busy2=0. Then WE_A=1, WA_A=15, WD_A=0xDEAD -> next cycle RA2=15 still returns PC_in, and RA2=0..14 are unchanged.
- Dual write, distinct addresses: WA_A=1/WD_A=0xA, WA_B=2/WD_B=0xB -> next cycle R1=0xA, R2=0xB.
- Dual write, same address: WA_A=WA_B=5, WD_A=0x11, WD_B=0x22 -> R5=0x11.
- Scoreboard sequence on R4:
  - Claim R4 -> Busy=1 and AnyBusy=1 next cycle;
  - port-B write R4=0x77 -> Busy=0 and R4=0x77;
  - repeat with Claim R4 and WE_B to R4 in the same cycle -> Busy stays 1.
- Bypass, read RA3=6 in the same cycle as WE_A to R6 with WD_A=0x99, previous R6 value 0x10:
  - with REGFILE_BYPASS_EN -> RD3=0x99;
  - without it -> RD3=0x10 this cycle and 0x99 the next.
